// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a simple dual-port RAM: the write port and
// the read port are arbitrated independently, each with its own round-robin pointer.
module ram_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [7:0]        conflict_cnt
);

  localparam int NUM_PORTS = 2;  // 0 = write port, 1 = read port

  logic [1:0]              req, we, gnt_q, rvalid_q;
  logic [1:0][ADDR_W-1:0]  addr;
  logic [1:0][DATA_W-1:0]  wdata;

  logic [NUM_PORTS-1:0][1:0] cand;
  logic [NUM_PORTS-1:0]      sel, last, grant;
  logic                      collide;
  logic                      rd_who;

  assign req   = {req1, req0};
  assign we    = {we1, we0};
  assign addr  = {addr1, addr0};
  assign wdata = {wdata1, wdata0};

  // A requester whose grant is still showing is locked out for this edge.
  assign cand[0] = req &  we & ~gnt_q;
  assign cand[1] = req & ~we & ~gnt_q;

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign sel[p] = (cand[p] == 2'b11) ? ~last[p] : cand[p][1];
    end
  endgenerate

  // A read aimed at the word being written this edge waits one edge.
  assign collide  = grant[0] && (|cand[1]) && (addr[sel[1]] == addr[sel[0]]);
  assign grant[0] = |cand[0];
  assign grant[1] = (|cand[1]) && !collide;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last <= '1;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (grant[p]) last[p] <= sel[p];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q        <= '0;
      rvalid_q     <= '0;
      ram_en       <= 1'b0;
      ram_wr_en    <= 1'b0;
      ram_rd_en    <= 1'b0;
      ram_wr_addr  <= '0;
      ram_rd_addr  <= '0;
      ram_wr_data  <= '0;
      rd_who       <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      gnt_q     <= ({1'b0, grant[0]} << sel[0]) | ({1'b0, grant[1]} << sel[1]);
      ram_wr_en <= grant[0];
      ram_rd_en <= grant[1];
      ram_en    <= grant[0] | grant[1];
      if (grant[0]) begin
        ram_wr_addr <= addr[sel[0]];
        ram_wr_data <= wdata[sel[0]];
      end
      if (grant[1]) begin
        ram_rd_addr <= addr[sel[1]];
        rd_who      <= sel[1];
      end
      // RAM returns data the cycle after the read strobe.
      rvalid_q <= {ram_rd_en & rd_who, ram_rd_en & ~rd_who};
      if (collide && conflict_cnt != 8'hFF)
        conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign rdata0  = ram_rd_data;
  assign rdata1  = ram_rd_data;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, RAM data width.
REQ-002 Parameter ADDR_W, default 5, RAM address width (32 words).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 req0/req1  input  1  requester 0/1 access request, held until granted.
REQ-006 we0/we1  input  1  1 = write, 0 = read; stable while req high.
REQ-007 addr0/addr1  input  ADDR_W  access address; stable while req high.
REQ-008 wdata0/wdata1  input  DATA_W  write data; stable while req high.
REQ-009 gnt0/gnt1  output  1  one-cycle pulse: request accepted.
REQ-010 rvalid0/rvalid1  output  1  one-cycle pulse: read data valid on rdata0/rdata1.
REQ-011 rdata0/rdata1  output  DATA_W  read data; both driven from ram_rd_data.
REQ-012 ram_en, ram_wr_en, ram_rd_en  output  1  RAM strobes.
REQ-013 ram_wr_addr, ram_rd_addr  output  ADDR_W  RAM addresses.
REQ-014 ram_wr_data  output  DATA_W  RAM write data.
REQ-015 ram_rd_data  input  DATA_W  RAM read data, valid the cycle after ram_rd_en high.
REQ-016 conflict_cnt  output  8  saturating count of deferred reads.

Function
REQ-017 Outputs gnt*, ram_*, rvalid*, conflict_cnt SHALL be registered.
REQ-018 Write port and read port SHALL be arbitrated independently, each sampled every rising edge.
REQ-019 Write candidates: reqi & wei & ~gnti; read candidates: reqi & ~wei & ~gnti (lockout: no regrant while own gnt high).
REQ-020 Each port SHALL use a 1-bit round-robin pointer: with both candidates, grant the requester not last granted on that port; pointer updates only on a grant.
REQ-021 Write grant at edge N: cycle N+1 gnti=1, ram_wr_en=1, ram_wr_addr=addri, ram_wr_data=wdatai.
REQ-022 Read grant at edge N: cycle N+1 gnti=1, ram_rd_en=1, ram_rd_addr=addri; cycle N+2 rvalidi=1, rdatai=ram_rd_data.
REQ-023 Both ports SHALL grant in the same cycle when requester 0 writes and requester 1 reads, or vice versa.
REQ-024 Collision: read candidate address equal to the granted write address in the same cycle -> read not granted, write proceeds, read granted at next edge; conflict_cnt increments, saturates at 255.
REQ-025 ram_en SHALL equal ram_wr_en | ram_rd_en.
REQ-026 Idle cycles: all strobes, gnt*, rvalid* low; address/data outputs hold last value.
REQ-027 Max throughput per requester: one grant every 2 cycles; per port: one access per cycle.
REQ-028 Requester SHALL drop or change its request no later than the edge after gnt; a req still high after lockout is a new request.

Reset
REQ-029 rst=0 at an edge SHALL clear gnt*, rvalid*, ram_* strobes, addresses, write data, conflict_cnt to 0 and both pointers to favour requester 0.
REQ-030 Reset mid-operation SHALL cancel a pending rvalid; no strobe asserted in the cycle after a reset edge.
REQ-031 No grants while rst=0; first grant possible at the first edge with rst=1.

Verification
REQ-032 req0 write addr 3 data 8'hA5 -> gnt0 next cycle, ram_wr_en=1, ram_wr_addr=3, ram_wr_data=A5; then req0 read addr 3 -> rvalid0=1 with rdata0=A5 two cycles after sampling edge.
REQ-033 req0 and req1 both write (addr 1, 2) held continuously -> grants alternate 0,1,0,1 from reset; no requester granted twice consecutively.
REQ-034 req0 write addr 7, req1 read addr 9 same edge -> gnt0 and gnt1 same cycle, ram_wr_en and ram_rd_en both high, ram_en=1.
REQ-035 req0 write addr 4, req1 read addr 4 same edge -> write granted first, read granted one cycle later, conflict_cnt=1; rdata1 equals new write data.
REQ-036 Issue read, assert rst=0 in cycle ram_rd_en=1 -> rvalid never asserts, all outputs 0, next read after release granted to requester 0 first.
REQ-037 256 forced collisions -> conflict_cnt stops at 255.
